// File: rtl/uart_rx_fc.sv
// 8N1 UART receiver with a small show-ahead byte FIFO and CTS flow control.
// All bit timing advances on OversampleTick; bytes are taken at the stop-bit sample.
module uart_rx_fc #(
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CTS_HEADROOM = 2
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       RxD_ser,
    input  logic       OversampleTick,
    input  logic       rd_en,
    output logic [7:0] RxD_par,
    output logic       RxD_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       CTS
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] HEADROOM  = LVL_W'(CTS_HEADROOM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Synchronizer, preset to the idle (mark) level
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RxD_ser;
            rx_s    <= rx_meta;
        end
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shreg;
    logic [7:0]       shreg_next;
    logic             push_c;
    logic             ferr_c;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
        end
    end

    // Frame FSM: start qualification at mid start bit, then one sample per bit period
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        push_c       = 1'b0;
        ferr_c       = 1'b0;
        if (OversampleTick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_next = S_START;
                        cnt_next   = '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt_next = '0;
                        if (!rx_s) begin
                            state_next   = S_DATA;
                            bit_idx_next = '0;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt_next            = '0;
                        shreg_next[bit_idx] = rx_s;
                        bit_idx_next        = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state_next = S_STOP;
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt_next = '0;
                        if (rx_s) begin
                            push_c     = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            ferr_c     = 1'b1;
                            state_next = S_BREAK;
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Show-ahead FIFO
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             full_c;
    logic             pop_c;
    logic             do_push_c;
    logic             ovr_c;
    logic [PTR_W-1:0] rd_ptr_next_c;
    logic [LVL_W-1:0] count_next_c;
    logic [LVL_W-1:0] free_next_c;
    logic [7:0]       head_next_c;

    always_comb begin
        full_c        = (count == DEPTH_LVL);
        pop_c         = rd_en && RxD_valid;
        do_push_c     = push_c && (!full_c || pop_c);
        ovr_c         = push_c && full_c && !pop_c;
        rd_ptr_next_c = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_next_c  = count;
        if (do_push_c && !pop_c) begin
            count_next_c = count + LVL_W'(1);
        end else if (!do_push_c && pop_c) begin
            count_next_c = count - LVL_W'(1);
        end
        free_next_c = DEPTH_LVL - count_next_c;
        // A byte written this cycle becomes the head when it lands on the next read slot
        if (do_push_c && (wr_ptr == rd_ptr_next_c)) begin
            head_next_c = shreg;
        end else begin
            head_next_c = mem[rd_ptr_next_c];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            RxD_par   <= '0;
            RxD_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            CTS       <= 1'b0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_next_c;
            count     <= count_next_c;
            RxD_valid <= (count_next_c != '0);
            if (count_next_c != '0) begin
                RxD_par <= head_next_c;
            end
            frame_err <= ferr_c;
            overrun   <= ovr_c;
            CTS       <= (free_next_c >= HEADROOM);
        end
    end

endmodule

// File: tb/tb_uart_rx_fc.sv
// Directed bench for uart_rx_fc: single byte, glitch, framing/break, overflow, full push+pop, reset mid-frame.
`timescale 1ns/1ps
module tb_uart_rx_fc;

    logic       sys_clk;
    logic       rst;
    logic       RxD_ser;
    logic       OversampleTick;
    logic       rd_en;
    logic [7:0] RxD_par;
    logic       RxD_valid;
    logic       frame_err;
    logic       overrun;
    logic       CTS;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_count = 0;
    int ov_count = 0;
    int both_count = 0;

    uart_rx_fc #(.OVERSAMPLE(16), .FIFO_DEPTH(4), .CTS_HEADROOM(2)) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .RxD_ser       (RxD_ser),
        .OversampleTick(OversampleTick),
        .rd_en         (rd_en),
        .RxD_par       (RxD_par),
        .RxD_valid     (RxD_valid),
        .frame_err     (frame_err),
        .overrun       (overrun),
        .CTS           (CTS)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Tick on every second clock edge
    initial begin
        OversampleTick = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1 OversampleTick = 1'b1;
            @(posedge sys_clk);
            #1 OversampleTick = 1'b0;
        end
    end

    always @(posedge sys_clk) begin
        if (frame_err === 1'b1) fe_count <= fe_count + 1;
        if (overrun === 1'b1) ov_count <= ov_count + 1;
        if (frame_err === 1'b1 && overrun === 1'b1) both_count <= both_count + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Returns on the clock edge where the n-th further tick is sampled
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            while (OversampleTick !== 1'b1) @(posedge sys_clk);
        end
    endtask

    // Start and data bits, then the stop level; returns just after the stop level is driven
    task automatic send_until_stop(input logic [7:0] d, input logic stop);
        wait_ticks(2);
        #1 RxD_ser = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_ticks(16);
            #1 RxD_ser = d[i];
        end
        wait_ticks(16);
        #1 RxD_ser = stop;
    endtask

    task automatic finish_frame(input int done);
        wait_ticks(16 - done);
        #1 RxD_ser = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_until_stop(d, 1'b1);
        finish_frame(0);
    endtask

    task automatic pop_one();
        @(negedge sys_clk);
        rd_en = 1'b1;
        @(negedge sys_clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        RxD_ser = 1'b1;
        rd_en = 1'b0;
        repeat (4) @(negedge sys_clk);
        n_checks++;
        if ({RxD_valid, frame_err, overrun, CTS} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got valid/ferr/ovr/cts=%b required 0000", {RxD_valid, frame_err, overrun, CTS});
        end
        n_checks++;
        if (RxD_par !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_par: got %h required 00", RxD_par);
        end
        rst = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if (CTS !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cts_rise: got %b required 1", CTS);
        end
    endtask

    task automatic test_single_byte();
        send_until_stop(8'hA5, 1'b1);
        wait_ticks(9);
        @(negedge sys_clk);
        n_checks++;
        if (RxD_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_before_stop: got valid=%b required 0", RxD_valid);
        end
        wait_ticks(1);
        @(negedge sys_clk);
        n_checks++;
        if (RxD_valid !== 1'b1 || RxD_par !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_latency: got valid=%b par=%h required 1/a5", RxD_valid, RxD_par);
        end
        n_checks++;
        if (CTS !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cts: got %b required 1", CTS);
        end
        finish_frame(10);
        pop_one();
        n_checks++;
        if (RxD_valid !== 1'b0 || fe_count !== 0) begin
            n_fail++;
            $display("FAIL single_pop: got valid=%b ferr_count=%0d required 0/0", RxD_valid, fe_count);
        end
    endtask

    task automatic test_glitch();
        int fe0 = fe_count;
        wait_ticks(2);
        #1 RxD_ser = 1'b0;
        wait_ticks(5);
        #1 RxD_ser = 1'b1;
        wait_ticks(200);
        @(negedge sys_clk);
        n_checks++;
        if (RxD_valid !== 1'b0 || fe_count !== fe0) begin
            n_fail++;
            $display("FAIL glitch_reject: got valid=%b ferr_count=%0d required 0/%0d", RxD_valid, fe_count, fe0);
        end
        send_byte(8'h69);
        @(negedge sys_clk);
        n_checks++;
        if (RxD_valid !== 1'b1 || RxD_par !== 8'h69) begin
            n_fail++;
            $display("FAIL glitch_next_byte: got valid=%b par=%h required 1/69", RxD_valid, RxD_par);
        end
        pop_one();
    endtask

    task automatic test_frame_err();
        int fe0 = fe_count;
        int ov0 = ov_count;
        send_until_stop(8'h3C, 1'b0);
        wait_ticks(16 * 30);
        @(negedge sys_clk);
        n_checks++;
        if (fe_count !== fe0 + 1) begin
            n_fail++;
            $display("FAIL ferr_pulses: got %0d required %0d", fe_count - fe0, 1);
        end
        n_checks++;
        if (RxD_valid !== 1'b0 || ov_count !== ov0) begin
            n_fail++;
            $display("FAIL ferr_no_push: got valid=%b ovr_count=%0d required 0/%0d", RxD_valid, ov_count, ov0);
        end
        #1 RxD_ser = 1'b1;
        wait_ticks(4);
        send_byte(8'h5A);
        @(negedge sys_clk);
        n_checks++;
        if (RxD_valid !== 1'b1 || RxD_par !== 8'h5A || fe_count !== fe0 + 1) begin
            n_fail++;
            $display("FAIL ferr_recover: got valid=%b par=%h ferr=%0d required 1/5a/%0d", RxD_valid, RxD_par, fe_count - fe0, 1);
        end
        pop_one();
    endtask

    task automatic test_overrun();
        logic [7:0] exp_b [4];
        int ov0 = ov_count;
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge sys_clk);
        n_checks++;
        if (CTS !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_cts_two: got %b required 1", CTS);
        end
        send_byte(8'h33);
        @(negedge sys_clk);
        n_checks++;
        if (CTS !== 1'b0 || RxD_par !== 8'h11) begin
            n_fail++;
            $display("FAIL ovr_cts_three: got cts=%b par=%h required 0/11", CTS, RxD_par);
        end
        send_byte(8'h44);
        send_byte(8'h55);
        @(negedge sys_clk);
        n_checks++;
        if (ov_count !== ov0 + 1) begin
            n_fail++;
            $display("FAIL ovr_pulse: got %0d required %0d", ov_count - ov0, 1);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (RxD_valid !== 1'b1 || RxD_par !== exp_b[i]) begin
                n_fail++;
                $display("FAIL ovr_drain%0d: got valid=%b par=%h required 1/%h", i, RxD_valid, RxD_par, exp_b[i]);
            end
            pop_one();
        end
        n_checks++;
        if (RxD_valid !== 1'b0 || CTS !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_empty: got valid=%b cts=%b required 0/1", RxD_valid, CTS);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_b [4];
        int ov0 = ov_count;
        exp_b = '{8'hC2, 8'hC3, 8'hC4, 8'hC5};
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        send_byte(8'hC4);
        send_until_stop(8'hC5, 1'b1);
        wait_ticks(9);
        @(negedge sys_clk);
        @(posedge sys_clk);
        @(negedge sys_clk);
        rd_en = 1'b1;
        @(negedge sys_clk);
        rd_en = 1'b0;
        n_checks++;
        if (overrun !== 1'b0 || ov_count !== ov0) begin
            n_fail++;
            $display("FAIL full_pop_no_ovr: got ovr=%b count=%0d required 0/%0d", overrun, ov_count, ov0);
        end
        finish_frame(10);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (RxD_valid !== 1'b1 || RxD_par !== exp_b[i]) begin
                n_fail++;
                $display("FAIL full_drain%0d: got valid=%b par=%h required 1/%h", i, RxD_valid, RxD_par, exp_b[i]);
            end
            pop_one();
        end
        n_checks++;
        if (RxD_valid !== 1'b0 || ov_count !== ov0) begin
            n_fail++;
            $display("FAIL full_empty: got valid=%b ovr=%0d required 0/%0d", RxD_valid, ov_count, ov0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fe0 = fe_count;
        send_byte(8'h77);
        wait_ticks(2);
        #1 RxD_ser = 1'b0;
        wait_ticks(16);
        #1 RxD_ser = 1'b1;
        wait_ticks(16 * 4 + 8);
        @(negedge sys_clk);
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if ({RxD_valid, frame_err, overrun, CTS} !== 4'b0000 || RxD_par !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_outputs: got valid/ferr/ovr/cts=%b par=%h required 0000/00", {RxD_valid, frame_err, overrun, CTS}, RxD_par);
        end
        rst = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if (CTS !== 1'b1 || RxD_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release: got cts=%b valid=%b required 1/0", CTS, RxD_valid);
        end
        wait_ticks(200);
        send_byte(8'h12);
        @(negedge sys_clk);
        n_checks++;
        if (RxD_valid !== 1'b1 || RxD_par !== 8'h12 || fe_count !== fe0) begin
            n_fail++;
            $display("FAIL midrst_next: got valid=%b par=%h ferr=%0d required 1/12/%0d", RxD_valid, RxD_par, fe_count, fe0);
        end
        pop_one();
        n_checks++;
        if (RxD_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_pop: got valid=%b required 0", RxD_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_push_pop();
        test_reset_mid_frame();
        n_checks++;
        if (both_count !== 0) begin
            n_fail++;
            $display("FAIL same_cycle_pulses: got %0d required 0", both_count);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
